// File: rtl/instruction_decode_stage.sv
// Instruction decode stage: IF/ID register, 32x32 register file with a
// write-back port, field decode, load-use hazard detection and an ID/EX
// register.
//
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   IF_Instruction    fetched instruction
//   IF_PCPlus4        PC+4 of the fetched instruction
//   Flush             squash IF/ID and ID/EX (branch taken downstream)
//   WB_RegWrite/WB_WriteReg/WB_WriteData   register-file write-back port
//   Stall             combinational load-use stall request to fetch
//   DE_*              registered ID/EX payload
module instruction_decode_stage #(
   parameter logic [5:0] LW_OPCODE = 6'h23,
   parameter logic [5:0] SW_OPCODE = 6'h2B,
   parameter bit         WB_BYPASS = 1'b1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] IF_Instruction,
   input  logic [31:0] IF_PCPlus4,
   input  logic        Flush,
   input  logic        WB_RegWrite,
   input  logic [4:0]  WB_WriteReg,
   input  logic [31:0] WB_WriteData,
   output logic        Stall,
   output logic        DE_Valid,
   output logic [31:0] DE_PCPlus4,
   output logic [31:0] DE_ReadData1,
   output logic [31:0] DE_ReadData2,
   output logic [31:0] DE_SignExt,
   output logic [4:0]  DE_Rs,
   output logic [4:0]  DE_Rt,
   output logic [4:0]  DE_Rd,
   output logic [5:0]  DE_Opcode,
   output logic [5:0]  DE_Funct,
   output logic        DE_MemRead,
   output logic        DE_MemWrite
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned RAW   = 5;
   localparam int unsigned NREGS = 32;

   // ID/EX payload
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc_plus4;
      logic [XLEN-1:0] read_data1;
      logic [XLEN-1:0] read_data2;
      logic [XLEN-1:0] sign_ext;
      logic [RAW-1:0]  rs;
      logic [RAW-1:0]  rt;
      logic [RAW-1:0]  rd;
      logic [5:0]      opcode;
      logic [5:0]      funct;
      logic            mem_read;
      logic            mem_write;
   } de_t;

   logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
   logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
   logic            ifid_valid_q, ifid_valid_d;
   logic [XLEN-1:0] rf_q [NREGS];
   logic [XLEN-1:0] rf_d [NREGS];
   de_t             de_q, de_d;

   logic [RAW-1:0]  ifid_rs, ifid_rt;
   logic [XLEN-1:0] rd1_c, rd2_c;
   logic            wb_en_c;

   assign ifid_rs = ifid_instr_q[25:21];
   assign ifid_rt = ifid_instr_q[20:16];
   assign wb_en_c = WB_RegWrite && (WB_WriteReg != '0);

   // Load in ID/EX whose destination is a source of the instruction in IF/ID
   assign Stall = ifid_valid_q & de_q.valid & de_q.mem_read & (de_q.rt != '0) &
                  ((de_q.rt == ifid_rs) | (de_q.rt == ifid_rt));

   // Register read with $0 hard-wired and optional write-first bypass
   always_comb begin
      rd1_c = '0;
      rd2_c = '0;
      if (ifid_rs != '0) begin
         if (WB_BYPASS && wb_en_c && (WB_WriteReg == ifid_rs)) rd1_c = WB_WriteData;
         else                                                   rd1_c = rf_q[ifid_rs];
      end
      if (ifid_rt != '0) begin
         if (WB_BYPASS && wb_en_c && (WB_WriteReg == ifid_rt)) rd2_c = WB_WriteData;
         else                                                   rd2_c = rf_q[ifid_rt];
      end
   end

   // Register-file write-back, independent of stall and flush
   always_comb begin
      rf_d = rf_q;
      if (wb_en_c) rf_d[WB_WriteReg] = WB_WriteData;
   end

   // IF/ID next state: flush clears, stall holds, otherwise capture
   always_comb begin
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
      if (Flush) begin
         ifid_instr_d = '0;
         ifid_pc4_d   = '0;
         ifid_valid_d = 1'b0;
      end else if (!Stall) begin
         ifid_instr_d = IF_Instruction;
         ifid_pc4_d   = IF_PCPlus4;
         ifid_valid_d = 1'b1;
      end
   end

   // ID/EX next state: bubble on flush, stall or empty IF/ID
   always_comb begin
      de_d = '0;
      if (!Flush && !Stall && ifid_valid_q) begin
         de_d.valid      = 1'b1;
         de_d.pc_plus4   = ifid_pc4_q;
         de_d.read_data1 = rd1_c;
         de_d.read_data2 = rd2_c;
         de_d.sign_ext   = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};
         de_d.rs         = ifid_rs;
         de_d.rt         = ifid_rt;
         de_d.rd         = ifid_instr_q[15:11];
         de_d.opcode     = ifid_instr_q[31:26];
         de_d.funct      = ifid_instr_q[5:0];
         de_d.mem_read   = (ifid_instr_q[31:26] == LW_OPCODE);
         de_d.mem_write  = (ifid_instr_q[31:26] == SW_OPCODE);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ifid_instr_q <= '0;
         ifid_pc4_q   <= '0;
         ifid_valid_q <= 1'b0;
         rf_q         <= '{default: '0};
         de_q         <= '0;
      end else begin
         ifid_instr_q <= ifid_instr_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
         rf_q         <= rf_d;
         de_q         <= de_d;
      end
   end

   assign DE_Valid     = de_q.valid;
   assign DE_PCPlus4   = de_q.pc_plus4;
   assign DE_ReadData1 = de_q.read_data1;
   assign DE_ReadData2 = de_q.read_data2;
   assign DE_SignExt   = de_q.sign_ext;
   assign DE_Rs        = de_q.rs;
   assign DE_Rt        = de_q.rt;
   assign DE_Rd        = de_q.rd;
   assign DE_Opcode    = de_q.opcode;
   assign DE_Funct     = de_q.funct;
   assign DE_MemRead   = de_q.mem_read;
   assign DE_MemWrite  = de_q.mem_write;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Self-checking bench for instruction_decode_stage: directed scenarios plus a
// randomized run, all compared against a behavioural pipeline model.
module tb_instruction_decode_stage;

   logic        Clk = 1'b0;
   logic        Reset, Flush, WB_RegWrite;
   logic [31:0] IF_Instruction, IF_PCPlus4, WB_WriteData;
   logic [4:0]  WB_WriteReg;
   logic        Stall, DE_Valid, DE_MemRead, DE_MemWrite;
   logic [31:0] DE_PCPlus4, DE_ReadData1, DE_ReadData2, DE_SignExt;
   logic [4:0]  DE_Rs, DE_Rt, DE_Rd;
   logic [5:0]  DE_Opcode, DE_Funct;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   instruction_decode_stage dut (
      .Clk(Clk), .Reset(Reset), .IF_Instruction(IF_Instruction), .IF_PCPlus4(IF_PCPlus4),
      .Flush(Flush), .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
      .WB_WriteData(WB_WriteData), .Stall(Stall), .DE_Valid(DE_Valid),
      .DE_PCPlus4(DE_PCPlus4), .DE_ReadData1(DE_ReadData1), .DE_ReadData2(DE_ReadData2),
      .DE_SignExt(DE_SignExt), .DE_Rs(DE_Rs), .DE_Rt(DE_Rt), .DE_Rd(DE_Rd),
      .DE_Opcode(DE_Opcode), .DE_Funct(DE_Funct), .DE_MemRead(DE_MemRead),
      .DE_MemWrite(DE_MemWrite)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] pc4, rd1, rd2, sext;
      logic [4:0]  rs, rt, rd;
      logic [5:0]  opcode, funct;
      logic        mem_read, mem_write;
   } de_t;

   de_t dut_de;
   assign dut_de = {DE_Valid, DE_PCPlus4, DE_ReadData1, DE_ReadData2, DE_SignExt,
                    DE_Rs, DE_Rt, DE_Rd, DE_Opcode, DE_Funct, DE_MemRead, DE_MemWrite};

   // Behavioural model: architectural registers, the decode slot and the ID/EX view
   logic [31:0] m_regs [32];
   logic [31:0] m_instr, m_pc4;
   logic        m_valid;
   de_t         m_de;

   function automatic logic model_stall();
      logic [4:0] rs, rt;
      rs = m_instr[25:21];
      rt = m_instr[20:16];
      return m_valid && m_de.valid && m_de.mem_read && (m_de.rt != 0) &&
             (m_de.rt == rs || m_de.rt == rt);
   endfunction

   function automatic logic [31:0] reg_value(input logic [4:0] idx);
      if (idx == 0) return 32'h0;
      if (WB_RegWrite && WB_WriteReg == idx) return WB_WriteData;
      return m_regs[idx];
   endfunction

   function automatic void model_edge();
      de_t nd;
      logic st;
      nd = '0;
      if (Reset) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
         m_instr = 0; m_pc4 = 0; m_valid = 0; m_de = '0;
         return;
      end
      st = model_stall();
      if (!Flush && !st && m_valid) begin
         nd.valid     = 1'b1;
         nd.pc4       = m_pc4;
         nd.rs        = m_instr[25:21];
         nd.rt        = m_instr[20:16];
         nd.rd        = m_instr[15:11];
         nd.opcode    = m_instr[31:26];
         nd.funct     = m_instr[5:0];
         nd.rd1       = reg_value(nd.rs);
         nd.rd2       = reg_value(nd.rt);
         nd.sext      = 32'($signed(m_instr[15:0]));
         nd.mem_read  = (nd.opcode == 6'h23);
         nd.mem_write = (nd.opcode == 6'h2B);
      end
      if (Flush) begin
         m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (!st) begin
         m_instr = IF_Instruction; m_pc4 = IF_PCPlus4; m_valid = 1;
      end
      if (WB_RegWrite && WB_WriteReg != 0) m_regs[WB_WriteReg] = WB_WriteData;
      m_de = nd;
   endfunction

   task automatic drive(input logic rst, input logic fl, input logic [31:0] ins,
                        input logic [31:0] pc4, input logic we, input logic [4:0] wr,
                        input logic [31:0] wd);
      Reset = rst; Flush = fl; IF_Instruction = ins; IF_PCPlus4 = pc4;
      WB_RegWrite = we; WB_WriteReg = wr; WB_WriteData = wd;
      #1;
   endtask

   task automatic tick();
      @(posedge Clk);
      model_edge();
      #1;
   endtask

   localparam logic [31:0] NOP = 32'h0;

   task automatic test_reset();
      logic [31:0] ins;
      drive(1, 1, 32'h8C220000, 32'h40, 1, 5'd9, 32'hFFFF);
      tick();
      drive(1, 0, 32'h8C220000, 32'h44, 0, 5'd0, 0);
      tick();
      checks++;
      if (dut_de !== de_t'('0)) begin
         errors++; $display("FAIL reset_de actual=%h required=0", dut_de);
      end
      checks++;
      if (Stall !== 1'b0) begin
         errors++; $display("FAIL reset_stall actual=%b required=0", Stall);
      end
      for (int i = 1; i <= 32; i++) begin
         ins = {6'h00, 5'(i), 5'(32 - i), 5'd1, 5'd0, 6'h20};
         drive(0, 0, ins, 32'(4 * i), 0, 5'd0, 0);
         tick();
         checks++;
         if (dut_de !== m_de) begin
            errors++; $display("FAIL reset_read actual=%h required=%h", dut_de, m_de);
         end
      end
   endtask

   task automatic test_writeback_read();
      drive(0, 0, NOP, 32'h0, 1, 5'd5, 32'hDEADBEEF);
      tick();
      drive(0, 0, 32'h00A01820, 32'h4, 0, 5'd0, 0);
      tick();
      drive(0, 0, NOP, 32'h8, 0, 5'd0, 0);
      tick();
      checks++;
      if ({DE_ReadData1, DE_Rd, DE_PCPlus4, DE_Valid} !== {32'hDEADBEEF, 5'd3, 32'h4, 1'b1}) begin
         errors++;
         $display("FAIL wb_read actual rd1=%h rd=%0d pc4=%h v=%b required rd1=deadbeef rd=3 pc4=4 v=1",
                  DE_ReadData1, DE_Rd, DE_PCPlus4, DE_Valid);
      end
      checks++;
      if (dut_de !== m_de) begin
         errors++; $display("FAIL wb_read_model actual=%h required=%h", dut_de, m_de);
      end
   endtask

   task automatic test_load_use();
      drive(0, 0, 32'h8C220000, 32'h10, 0, 5'd0, 0);
      tick();
      drive(0, 0, 32'h00422020, 32'h14, 0, 5'd0, 0);
      tick();
      checks++;
      if (Stall !== 1'b1) begin
         errors++; $display("FAIL lu_stall actual=%b required=1", Stall);
      end
      tick();
      checks++;
      if ({DE_Valid, Stall} !== 2'b00) begin
         errors++; $display("FAIL lu_bubble actual valid=%b stall=%b required 0 0", DE_Valid, Stall);
      end
      drive(0, 0, NOP, 32'h18, 0, 5'd0, 0);
      tick();
      checks++;
      if ({DE_Valid, DE_Rs, DE_Rt, DE_Rd, DE_PCPlus4} !== {1'b1, 5'd2, 5'd2, 5'd4, 32'h14}) begin
         errors++;
         $display("FAIL lu_add actual v=%b rs=%0d rt=%0d rd=%0d pc4=%h required 1 2 2 4 14",
                  DE_Valid, DE_Rs, DE_Rt, DE_Rd, DE_PCPlus4);
      end
      checks++;
      if (dut_de !== m_de) begin
         errors++; $display("FAIL lu_model actual=%h required=%h", dut_de, m_de);
      end
   endtask

   task automatic test_flush();
      drive(0, 0, 32'h8C220000, 32'h20, 0, 5'd0, 0);
      tick();
      drive(0, 0, 32'h00422020, 32'h24, 0, 5'd0, 0);
      tick();
      checks++;
      if (Stall !== 1'b1) begin
         errors++; $display("FAIL fl_pending actual=%b required=1", Stall);
      end
      drive(0, 1, 32'h00A01820, 32'h28, 0, 5'd0, 0);
      tick();
      checks++;
      if ({DE_Valid, Stall} !== 2'b00) begin
         errors++; $display("FAIL fl_squash actual valid=%b stall=%b required 0 0", DE_Valid, Stall);
      end
      drive(0, 0, 32'h00E04020, 32'h80, 0, 5'd0, 0);
      tick();
      checks++;
      if (DE_Valid !== 1'b0) begin
         errors++; $display("FAIL fl_empty actual=%b required=0", DE_Valid);
      end
      drive(0, 0, NOP, 32'h84, 0, 5'd0, 0);
      tick();
      checks++;
      if ({DE_Valid, DE_Rs, DE_Rd, DE_PCPlus4} !== {1'b1, 5'd7, 5'd8, 32'h80}) begin
         errors++;
         $display("FAIL fl_resume actual v=%b rs=%0d rd=%0d pc4=%h required 1 7 8 80",
                  DE_Valid, DE_Rs, DE_Rd, DE_PCPlus4);
      end
   endtask

   task automatic test_bypass();
      drive(0, 0, 32'h00000820, 32'h30, 1, 5'd0, 32'h1234);
      tick();
      drive(0, 0, NOP, 32'h34, 1, 5'd0, 32'h1234);
      tick();
      checks++;
      if ({DE_ReadData1, DE_ReadData2} !== 64'h0) begin
         errors++; $display("FAIL zero_reg actual=%h %h required 0 0", DE_ReadData1, DE_ReadData2);
      end
      drive(0, 0, 32'h00E04020, 32'h38, 0, 5'd0, 0);
      tick();
      drive(0, 0, NOP, 32'h3C, 1, 5'd7, 32'h55);
      tick();
      checks++;
      if (DE_ReadData1 !== 32'h55) begin
         errors++; $display("FAIL bypass actual=%h required=00000055", DE_ReadData1);
      end
      checks++;
      if (dut_de !== m_de) begin
         errors++; $display("FAIL bypass_model actual=%h required=%h", dut_de, m_de);
      end
   endtask

   task automatic test_signext_reset();
      drive(0, 0, 32'h20218001, 32'h40, 0, 5'd0, 0);
      tick();
      drive(0, 0, NOP, 32'h44, 0, 5'd0, 0);
      tick();
      checks++;
      if (DE_SignExt !== 32'hFFFF8001) begin
         errors++; $display("FAIL signext actual=%h required=ffff8001", DE_SignExt);
      end
      drive(0, 0, 32'h8C220000, 32'h48, 0, 5'd0, 0);
      tick();
      drive(0, 0, 32'h00422020, 32'h4C, 0, 5'd0, 0);
      tick();
      checks++;
      if (Stall !== 1'b1) begin
         errors++; $display("FAIL rst_pending actual=%b required=1", Stall);
      end
      drive(1, 0, 32'h00422020, 32'h4C, 1, 5'd3, 32'h77);
      tick();
      checks++;
      if ({dut_de, Stall} !== {de_t'('0), 1'b0}) begin
         errors++; $display("FAIL rst_mid actual=%h stall=%b required=0 0", dut_de, Stall);
      end
      drive(0, 0, 32'h00A01820, 32'h4, 0, 5'd0, 0);
      tick();
      drive(0, 0, NOP, 32'h8, 0, 5'd0, 0);
      tick();
      checks++;
      if ({DE_Valid, DE_ReadData1} !== {1'b1, 32'h0}) begin
         errors++; $display("FAIL rst_regs actual v=%b rd1=%h required 1 0", DE_Valid, DE_ReadData1);
      end
   endtask

   task automatic test_random();
      logic [31:0] ins, pc;
      logic [5:0]  op;
      pc  = 32'h1000;
      ins = NOP;
      for (int n = 0; n < 400; n++) begin
         if (!model_stall()) begin
            case ($urandom_range(0, 3))
               0: op = 6'h23;
               1: op = 6'h2B;
               2: op = 6'h00;
               default: op = 6'($urandom);
            endcase
            ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            pc  = pc + 4;
         end
         drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8, ins, pc,
               1'($urandom), 5'($urandom_range(0, 4)), $urandom);
         checks++;
         if (Stall !== model_stall()) begin
            errors++; $display("FAIL rnd_stall n=%0d actual=%b required=%b", n, Stall, model_stall());
         end
         tick();
         checks++;
         if (dut_de !== m_de) begin
            errors++; $display("FAIL rnd_de n=%0d actual=%h required=%h", n, dut_de, m_de);
         end
      end
   endtask

   initial begin
      test_reset();
      test_writeback_read();
      test_load_use();
      test_flush();
      test_bypass();
      test_signext_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
